// File: rtl/ball_ctrl_pkg.sv
// Shared pong constants for the ball engine: display geometry, paddle body size,
// ball size, derived centre/bounds, and the ball FSM state encoding.
package ball_ctrl_pkg;

   localparam logic [10:0] H_DISP = 11'd640;
   localparam logic [10:0] V_DISP = 11'd480;
   localparam logic [10:0] SLDE_W = 11'd10;
   localparam logic [10:0] BODY_W = 11'd10;
   localparam logic [10:0] BODY_L = 11'd80;
   localparam logic [10:0] BALL_W = 11'd10;

   localparam logic [10:0] CX = (H_DISP >> 1) - (BALL_W >> 1);
   localparam logic [10:0] CY = (V_DISP >> 1) - (BALL_W >> 1);

   // Inner edges of the playfield for the ball's top-left corner.
   localparam logic [10:0] X_MAX = H_DISP - SLDE_W - BALL_W;
   localparam logic [10:0] Y_MAX = V_DISP - SLDE_W - BALL_W;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SERVE  = 3'd1,
      ST_PLAY   = 3'd2,
      ST_SCORED = 3'd3,
      ST_OVER   = 3'd4
   } state_t;

   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/ball_ctrl_move_tick.sv
// Free-running move-tick divider: counts 0..MOVE_DIV-1 and flags the last count.
// Shared by the ball engine and the paddle blocks so all movers update in phase.
module move_tick #(
   parameter int MOVE_DIV = 250000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(MOVE_DIV - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball motion and scoring engine: moves the ball per move tick, reflects off
// walls and paddles, detects goals, keeps scores. BALL_SPEEDUP_EN adds paddle-hit speedup.
module ball_ctrl
   import ball_ctrl_pkg::*;
#(
   parameter int MOVE_DIV    = 250000,
   parameter int SPEED0      = 2,
   parameter int SERVE_TICKS = 50,
   parameter int WIN_SCORE   = 9
) (
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic       start,
   input  logic [9:0] lpad_x,
   input  logic [9:0] lpad_y,
   input  logic [9:0] rpad_x,
   input  logic [9:0] rpad_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       hit,
   output logic       goal,
   output logic       game_over,
   output logic [2:0] fsm_state
);

   localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
   localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
   localparam logic [3:0] WIN = 4'(WIN_SCORE);
   localparam logic [10:0] STEP0 = 11'(SPEED0);

   logic tick;

   move_tick #(.MOVE_DIV(MOVE_DIV)) u_move_tick (
      .clk   (vga_clk),
      .rst_n (sys_rst_n),
      .tick  (tick)
   );

   state_t state, state_nx;
   logic [SW-1:0] serve_cnt, cnt_nx;
   logic [9:0] x_nx, y_nx;
   logic [3:0] sl_nx, sr_nx;
   logic dx, dy, dx_nx, dy_nx;
   logic hit_nx, goal_nx;

`ifdef BALL_SPEEDUP_EN
   localparam logic [10:0] STEP_MAX = 11'(SPEED0 + 2);
   logic [10:0] step;
`else
   logic [10:0] step;
   assign step = STEP0;
`endif

   // One PLAY-tick candidate move, all in 11-bit unsigned arithmetic.
   logic [10:0] cur_x, cur_y, lpx, lpy, rpx, rpy;
   logic [10:0] nx, raw_ny, ny, lface, rface;
   logic [9:0]  px, py;
   logic        nx_under, ny_under, pdx, pdy, ov_l, ov_r;
   logic        hit_l, hit_r, phit, score_to_l, score_to_r;

   always_comb begin
      cur_x = {1'b0, ball_x};
      cur_y = {1'b0, ball_y};
      lpx   = {1'b0, lpad_x};
      lpy   = {1'b0, lpad_y};
      rpx   = {1'b0, rpad_x};
      rpy   = {1'b0, rpad_y};

      nx_under = !dx && (cur_x < step);
      ny_under = !dy && (cur_y < step);
      nx       = dx ? cur_x + step : cur_x - step;
      raw_ny   = dy ? cur_y + step : cur_y - step;

      ny  = raw_ny;
      pdy = dy;
      if (!dy && (ny_under || raw_ny <= SLDE_W)) begin
         ny  = SLDE_W;
         pdy = 1'b1;
      end else if (dy && raw_ny >= Y_MAX) begin
         ny  = Y_MAX;
         pdy = 1'b0;
      end

      // Paddle tests use the wall-corrected y so a corner bounce can also hit.
      ov_l  = ((ny + BALL_W) > lpy) && (ny < (lpy + BODY_L));
      ov_r  = ((ny + BALL_W) > rpy) && (ny < (rpy + BODY_L));
      lface = lpx + BODY_W;
      rface = rpx - BALL_W;
      hit_l = !dx && ov_l && !nx_under && (nx <= lface) && (cur_x >= lface);
      hit_r = dx && ov_r && (nx >= rface) && (cur_x <= rface);

      px   = nx[9:0];
      pdx  = dx;
      phit = 1'b0;
      if (hit_l) begin
         px   = lface[9:0];
         pdx  = 1'b1;
         phit = 1'b1;
      end else if (hit_r) begin
         px   = rface[9:0];
         pdx  = 1'b0;
         phit = 1'b1;
      end
      py = ny[9:0];

      score_to_r = !phit && !dx && (nx_under || nx <= SLDE_W);
      score_to_l = !phit && dx && (nx >= X_MAX);
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = serve_cnt;
      x_nx     = ball_x;
      y_nx     = ball_y;
      dx_nx    = dx;
      dy_nx    = dy;
      sl_nx    = score_l;
      sr_nx    = score_r;
      hit_nx   = 1'b0;
      goal_nx  = 1'b0;
      if (tick) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state_nx = ST_SERVE;
                  cnt_nx   = '0;
               end
            end
            ST_SERVE: begin
               if (serve_cnt == SERVE_LAST) begin
                  state_nx = ST_PLAY;
               end else begin
                  cnt_nx = serve_cnt + SW'(1);
               end
            end
            ST_PLAY: begin
               x_nx   = px;
               y_nx   = py;
               dx_nx  = pdx;
               dy_nx  = pdy;
               hit_nx = phit;
               // dx is left unchanged on a goal: it already points at the conceding side.
               if (score_to_l || score_to_r) begin
                  goal_nx  = 1'b1;
                  state_nx = ST_SCORED;
                  if (score_to_l) begin
                     sl_nx = sat_inc(score_l, WIN);
                  end else begin
                     sr_nx = sat_inc(score_r, WIN);
                  end
               end
            end
            ST_SCORED: begin
               x_nx     = CX[9:0];
               y_nx     = CY[9:0];
               cnt_nx   = '0;
               state_nx = (score_l == WIN || score_r == WIN) ? ST_OVER : ST_SERVE;
            end
            ST_OVER: begin
               if (start) begin
                  state_nx = ST_SERVE;
                  sl_nx    = 4'd0;
                  sr_nx    = 4'd0;
                  dx_nx    = 1'b1;
                  cnt_nx   = '0;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         state     <= ST_IDLE;
         serve_cnt <= '0;
         ball_x    <= CX[9:0];
         ball_y    <= CY[9:0];
         dx        <= 1'b1;
         dy        <= 1'b1;
         score_l   <= 4'd0;
         score_r   <= 4'd0;
         hit       <= 1'b0;
         goal      <= 1'b0;
      end else begin
         state     <= state_nx;
         serve_cnt <= cnt_nx;
         ball_x    <= x_nx;
         ball_y    <= y_nx;
         dx        <= dx_nx;
         dy        <= dy_nx;
         score_l   <= sl_nx;
         score_r   <= sr_nx;
         hit       <= hit_nx;
         goal      <= goal_nx;
      end
   end

`ifdef BALL_SPEEDUP_EN
   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         step <= STEP0;
      end else if (state_nx == ST_SERVE && state != ST_SERVE) begin
         step <= STEP0;
      end else if (hit_nx && step < STEP_MAX) begin
         step <= step + 11'd1;
      end
   end
`endif

   assign game_over = (state == ST_OVER);
   assign fsm_state = state;

endmodule
